// File: rtl/imem_fetch_unit.sv
// ============================================================================
// Module   : imem_fetch_unit
// Purpose  : Instruction fetch initiator with a prefetch FIFO toward decode.
//            Define IMEM_FETCH_HALT_DETECT_EN to stop fetching on HALT_WORD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_fetch_unit #(
  parameter int          ADDR_W    = 6,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] HALT_WORD = 32'h0000000C
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_a,
  input  logic [31:0]       imem_rd,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_fetch_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_halted;
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_halt_hit;
  logic w_unused_bits;

  assign imem_a = r_fetch_pc[ADDR_W+1:2];
  assign w_full = (r_count == CNT_W'(DEPTH));

  // A redirect overrides both ends of the FIFO in the same cycle.
  assign w_pop  = out_valid & out_ready & ~redirect_valid;
  assign w_push = (~w_full | w_pop) & ~r_halted & ~redirect_valid;

`ifdef IMEM_FETCH_HALT_DETECT_EN
  assign w_halt_hit    = (imem_rd == HALT_WORD);
  assign w_unused_bits = ^redirect_pc[1:0];
`else
  assign w_halt_hit    = 1'b0;
  assign w_unused_bits = ^{redirect_pc[1:0], HALT_WORD};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_halted   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_halted   <= w_halt_hit;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= imem_rd;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
// ============================================================================
// Module   : tb_imem_fetch_unit
// Purpose  : Self-checking bench for imem_fetch_unit against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_unit;

  localparam int          ADDR_W    = 6;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] HALT_WORD = 32'h0000000C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] mem [64];
  assign imem_rd = mem[imem_a];

  always #5 clk = ~clk;

  imem_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_a        (imem_a),
    .imem_rd       (imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of fetched (pc, word) pairs.
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];
  logic [31:0] m_pc;
  bit          m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_in.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  task automatic compare_outputs(input string tag);
    if (q_pc.size() == 0) begin
      check({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, ".pc"},    out_pc,    32'h0);
      check({tag, ".instr"}, out_instr, 32'h0);
    end else begin
      check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, ".pc"},    out_pc,    q_pc[0]);
      check({tag, ".instr"}, out_instr, q_in[0]);
    end
    check({tag, ".imem_a"}, {26'b0, imem_a}, {26'b0, m_pc[7:2]});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halt});
  endtask

  // Called at a negedge: check, drive inputs, advance model, move to next negedge.
  task automatic step(input string tag, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          pop;
    bit          push;
    logic [31:0] word;
    compare_outputs(tag);
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (redir) begin
      q_pc.delete();
      q_in.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      pop  = (q_pc.size() != 0) && rdy;
      push = ((q_pc.size() < DEPTH) || pop) && !m_halt;
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (push) begin
        word = mem[m_pc[7:2]];
        q_pc.push_back(m_pc);
        q_in.push_back(word);
`ifdef IMEM_FETCH_HALT_DETECT_EN
        if (word == HALT_WORD) m_halt = 1'b1;
`endif
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i;
    model_reset();

    // Reset state with the clock running.
    repeat (2) @(negedge clk);
    compare_outputs("reset");
    reset_n = 1'b1;

    // Streaming with decode always ready.
    for (int i = 0; i < 10; i++) step("stream", 1'b1, 1'b0, 32'h0);

    // Back-pressure fills the FIFO, then drains in order.
    for (int i = 0; i < 10; i++) step("stall", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) step("drain", 1'b1, 1'b0, 32'h0);

    // Redirect to a misaligned target while full, with decode ready.
    for (int i = 0; i < 6; i++) step("fill", 1'b0, 1'b0, 32'h0);
    step("redir23", 1'b1, 1'b1, 32'h23);
    for (int i = 0; i < 5; i++) step("after23", 1'b1, 1'b0, 32'h0);

    // Word address wrap and 32-bit PC wrap.
    step("redirFC", 1'b1, 1'b1, 32'hFC);
    for (int i = 0; i < 5; i++) step("wrapA", 1'b1, 1'b0, 32'h0);
    step("redirTop", 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 8; i++) step("wrapPC", i[0], 1'b0, 32'h0);

`ifdef IMEM_FETCH_HALT_DETECT_EN
    mem[3] = HALT_WORD;
    step("redirH", 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) step("halt", 1'b1, 1'b0, 32'h0);
    check("halt.sticky", {31'b0, halted}, 32'd1);
    step("resume", 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step("resumed", 1'b1, 1'b0, 32'h0);
    mem[3] = 32'd3;
`endif

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step("prerst", 1'b0, 1'b0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with random memory contents and redirects.
    for (int i = 0; i < 64; i++) begin
      mem[i] = ($urandom_range(0, 7) == 0) ? HALT_WORD : $urandom;
    end
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
